// File: rtl/time_set_editor.sv
// time_set_editor: user-facing editor that produces the set-values and mode bus
// for a clock/calendar keeper. In RUN it drives mode=1 so the keeper free-runs.
// A mode press snapshots the keeper's time, sanitises it and drives mode=0 so the
// keeper continuously loads the *_d outputs. next/up/down then edit one field at
// a time with calendar-correct wrap, and a second mode press returns to RUN.
//
// Ports:
//   clk, rst                      system clock, synchronous active-high reset
//   btn_mode/next/up/down         one-cycle debounced button pulses
//   cur_year..cur_week            keeper's current time (wider than used)
//   year_d..sec_d, week_s         set values presented to the keeper
//   mode                          4'd1 = RUN, 4'd0 = SET
//   sel_field                     0=year 1=month 2=day 3=hour 4=minute 5=second 6=week
//   blink                         blanking square wave for the selected field
module time_set_editor #(
  parameter int unsigned YEAR_MIN     = 2000,
  parameter int unsigned YEAR_MAX     = 2099,
  parameter int unsigned BLINK_CYCLES = 25_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_mode,
  input  logic        btn_next,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic [15:0] cur_year,
  input  logic [5:0]  cur_month,
  input  logic [10:0] cur_day,
  input  logic [10:0] cur_hour,
  input  logic [10:0] cur_minute,
  input  logic [10:0] cur_second,
  input  logic [10:0] cur_week,
  output logic [14:0] year_d,
  output logic [3:0]  month_d,
  output logic [4:0]  day_d,
  output logic [5:0]  hour_d,
  output logic [5:0]  min_d,
  output logic [5:0]  sec_d,
  output logic [3:0]  week_s,
  output logic [3:0]  mode,
  output logic [2:0]  sel_field,
  output logic        blink
);

  localparam logic [14:0] Y_MIN = 15'(YEAR_MIN);
  localparam logic [14:0] Y_MAX = 15'(YEAR_MAX);
  localparam int unsigned CNT_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_CYCLES - 1);

  typedef enum logic {RUN, SET} state_t;

  state_t           state;
  logic [CNT_W-1:0] blink_cnt;

  // Gregorian leap rule; modulo by constants only, no general divider.
  function automatic logic is_leap(input logic [14:0] y);
    return ((y[1:0] == 2'b00) && ((y % 15'd100) != 15'd0)) ||
           ((y % 15'd400) == 15'd0);
  endfunction

  function automatic logic [4:0] dim_of(input logic [3:0] m, input logic [14:0] y);
    case (m)
      4'd2:                      return is_leap(y) ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11:   return 5'd30;
      default:                   return 5'd31;
    endcase
  endfunction

  // Upper bits of the keeper bus are deliberately dropped by truncation.
  logic unused_bits;
  assign unused_bits = ^{cur_year[15], cur_month[5:4], cur_day[10:5], cur_hour[10:6],
                         cur_minute[10:6], cur_second[10:6], cur_week[10:4]};

  // Snapshot of the keeper's time, truncated and forced into legal ranges.
  logic [14:0] cap_year;
  logic [3:0]  cap_month;
  logic [4:0]  cap_dim;
  logic [4:0]  cap_day;
  logic [5:0]  cap_hour;
  logic [5:0]  cap_min;
  logic [5:0]  cap_sec;
  logic [3:0]  cap_week;

  always_comb begin
    cap_year = cur_year[14:0];
    if ((cap_year < Y_MIN) || (cap_year > Y_MAX)) cap_year = Y_MIN;
    cap_month = cur_month[3:0];
    if ((cap_month == 4'd0) || (cap_month > 4'd12)) cap_month = 4'd1;
    // Day legality depends on the already-sanitised month and year.
    cap_dim = dim_of(cap_month, cap_year);
    cap_day = cur_day[4:0];
    if ((cap_day == 5'd0) || (cap_day > cap_dim)) cap_day = 5'd1;
    cap_hour = cur_hour[5:0];
    if (cap_hour > 6'd23) cap_hour = 6'd0;
    cap_min = cur_minute[5:0];
    if (cap_min > 6'd59) cap_min = 6'd0;
    cap_sec = cur_second[5:0];
    if (cap_sec > 6'd59) cap_sec = 6'd0;
    cap_week = cur_week[3:0];
    if ((cap_week == 4'd0) || (cap_week > 4'd7)) cap_week = 4'd1;
  end

  // An edit happens only when exactly one of up/down is pressed and neither
  // higher-priority button is.
  logic edit_c;
  assign edit_c = (btn_up ^ btn_down) & ~btn_next & ~btn_mode;

  // Candidate field values after an up (btn_up=1) or down edit of sel_field.
  logic [14:0] ed_year;
  logic [3:0]  ed_month;
  logic [4:0]  ed_day;
  logic [5:0]  ed_hour;
  logic [5:0]  ed_min;
  logic [5:0]  ed_sec;
  logic [3:0]  ed_week;
  logic [4:0]  cur_dim;
  logic [4:0]  new_dim;

  always_comb begin
    ed_year  = year_d;
    ed_month = month_d;
    ed_day   = day_d;
    ed_hour  = hour_d;
    ed_min   = min_d;
    ed_sec   = sec_d;
    ed_week  = week_s;
    cur_dim  = dim_of(month_d, year_d);
    new_dim  = cur_dim;
    case (sel_field)
      3'd0: begin
        if (btn_up) ed_year = (year_d >= Y_MAX) ? Y_MIN : year_d + 15'd1;
        else        ed_year = (year_d <= Y_MIN) ? Y_MAX : year_d - 15'd1;
        // Feb 29 must clamp when moving to a non-leap year.
        new_dim = dim_of(month_d, ed_year);
        if (day_d > new_dim) ed_day = new_dim;
      end
      3'd1: begin
        if (btn_up) ed_month = (month_d >= 4'd12) ? 4'd1 : month_d + 4'd1;
        else        ed_month = (month_d <= 4'd1) ? 4'd12 : month_d - 4'd1;
        new_dim = dim_of(ed_month, year_d);
        if (day_d > new_dim) ed_day = new_dim;
      end
      3'd2: begin
        if (btn_up) ed_day = (day_d >= cur_dim) ? 5'd1 : day_d + 5'd1;
        else        ed_day = (day_d <= 5'd1) ? cur_dim : day_d - 5'd1;
      end
      3'd3: begin
        if (btn_up) ed_hour = (hour_d >= 6'd23) ? 6'd0 : hour_d + 6'd1;
        else        ed_hour = (hour_d == 6'd0) ? 6'd23 : hour_d - 6'd1;
      end
      3'd4: begin
        if (btn_up) ed_min = (min_d >= 6'd59) ? 6'd0 : min_d + 6'd1;
        else        ed_min = (min_d == 6'd0) ? 6'd59 : min_d - 6'd1;
      end
      3'd5: begin
        if (btn_up) ed_sec = (sec_d >= 6'd59) ? 6'd0 : sec_d + 6'd1;
        else        ed_sec = (sec_d == 6'd0) ? 6'd59 : sec_d - 6'd1;
      end
      3'd6: begin
        if (btn_up) ed_week = (week_s >= 4'd7) ? 4'd1 : week_s + 4'd1;
        else        ed_week = (week_s <= 4'd1) ? 4'd7 : week_s - 4'd1;
      end
      default: ;
    endcase
  end

  // State machine, set-value registers and blink generator.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      mode      <= 4'd1;
      sel_field <= 3'd0;
      blink     <= 1'b0;
      blink_cnt <= '0;
      year_d    <= Y_MIN;
      month_d   <= 4'd1;
      day_d     <= 5'd1;
      hour_d    <= 6'd0;
      min_d     <= 6'd0;
      sec_d     <= 6'd0;
      week_s    <= 4'd1;
    end else begin
      case (state)
        RUN: begin
          blink_cnt <= '0;
          if (btn_mode) begin
            // Values and mode change together so the keeper never loads stale data.
            state     <= SET;
            mode      <= 4'd0;
            sel_field <= 3'd0;
            blink     <= 1'b1;
            year_d    <= cap_year;
            month_d   <= cap_month;
            day_d     <= cap_day;
            hour_d    <= cap_hour;
            min_d     <= cap_min;
            sec_d     <= cap_sec;
            week_s    <= cap_week;
          end else begin
            blink <= 1'b0;
          end
        end
        SET: begin
          if (btn_mode) begin
            state     <= RUN;
            mode      <= 4'd1;
            blink     <= 1'b0;
            blink_cnt <= '0;
          end else begin
            if (btn_next) begin
              sel_field <= (sel_field >= 3'd6) ? 3'd0 : sel_field + 3'd1;
            end
            if (edit_c) begin
              year_d    <= ed_year;
              month_d   <= ed_month;
              day_d     <= ed_day;
              hour_d    <= ed_hour;
              min_d     <= ed_min;
              sec_d     <= ed_sec;
              week_s    <= ed_week;
              // Keep the field visible while it is being adjusted.
              blink     <= 1'b1;
              blink_cnt <= '0;
            end else if (blink_cnt == CNT_LAST) begin
              blink     <= ~blink;
              blink_cnt <= '0;
            end else begin
              blink_cnt <= blink_cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          state <= RUN;
          mode  <= 4'd1;
        end
      endcase
    end
  end

endmodule
